// File: rtl/step_move_sequencer.sv
// Bus-programmable move sequencer: queues {steps, half-period, dir} segments and drives
// the step counter (clear/limit/done) and the motor driver step/dir pins for each one.
module step_move_sequencer #(
  parameter logic [15:0] BASE       = 16'h0010,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned SLACK      = 16,
  parameter int unsigned CLR_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr,
  input  logic        cs,
  input  logic        wr,
  input  logic        rd,
  input  logic [7:0]  data_in,
  output logic [7:0]  data_out,
  output logic        cnt_rst_n,
  output logic [15:0] limit_out,
  output logic        load_limit,
  input  logic        cnt_done,
  output logic        step_out,
  output logic        dir_out,
  output logic        irq
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [2:0] {StIdle, StPop, StClr, StLoad, StRun, StNext, StErr} state_e;

  state_e state_q, state_d;

  // Bus decode
  logic [15:0] off_full;
  logic [2:0]  off;
  logic        hit, wr_en, rd_en, push, ctrl_wr, abort, flag_clr;

  assign off_full = addr - BASE;
  assign off      = off_full[2:0];
  assign hit      = cs && (addr >= BASE) && (off_full < 16'd8);
  assign wr_en    = hit && wr;
  assign rd_en    = hit && rd;
  assign push     = wr_en && (off == 3'd3);
  assign ctrl_wr  = wr_en && (off == 3'd4);
  assign abort    = ctrl_wr && data_in[1];
  assign flag_clr = ctrl_wr && data_in[3];

  logic [15:0] seg_steps_q;
  logic [7:0]  seg_period_q;
  logic        run_en_q, irq_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_steps_q  <= '0;
      seg_period_q <= '0;
      run_en_q     <= 1'b0;
      irq_en_q     <= 1'b0;
    end else if (wr_en) begin
      case (off)
        3'd0: seg_steps_q[7:0]  <= data_in;
        3'd1: seg_steps_q[15:8] <= data_in;
        3'd2: seg_period_q      <= data_in;
        3'd4: begin
          run_en_q <= data_in[0];
          irq_en_q <= data_in[2];
        end
        default: ;
      endcase
    end
  end

  // Segment FIFO: entry = {steps[15:0], period[7:0], dir}
  logic [24:0]     fifo_q [FIFO_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full, empty, pop, do_push;
  logic [24:0]     head;

  assign full    = (count_q == CntW'(FIFO_DEPTH));
  assign empty   = (count_q == '0);
  assign pop     = (state_q == StPop);
  assign do_push = push && (!full || pop);
  assign head    = fifo_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) fifo_q[wr_ptr_q] <= {seg_steps_q, seg_period_q, data_in[0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (abort) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: ;
      endcase
    end
  end

  // Active segment and step generation state
  logic [15:0] act_steps_q;
  logic [7:0]  act_period_q, phase_q, phase_d, clr_cnt_q, clr_cnt_d;
  logic [17:0] issued_q, issued_d, step_lim;
  logic        step_q, step_d, done_seen_q, done_seen_d, done_now;
  logic        dir_q, cnt_rst_n_q, cnt_rst_n_d, load_q, load_d;
  logic [15:0] limit_q, limit_d;
  logic        overflow_q, timeout_q, irq_q;
  logic [7:0]  done_cnt_q, rdata_q, rdata_d;

  assign done_now = done_seen_q | cnt_done;
  assign step_lim = {2'b00, act_steps_q} + 18'(SLACK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: if (run_en_q && !empty) state_d = StPop;
      StPop:  state_d = (head[24:9] == 16'd0) ? StNext : StClr;
      StClr:  if (clr_cnt_q == 8'(CLR_CYCLES - 1)) state_d = StLoad;
      StLoad: state_d = StRun;
      StRun: begin
        // Once done is seen, let the high phase finish before leaving.
        if (done_now && (!step_q || phase_q == act_period_q)) state_d = StNext;
        else if (issued_q > step_lim)                         state_d = StErr;
      end
      StNext: state_d = (run_en_q && !empty) ? StPop : StIdle;
      StErr:  if (flag_clr) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_comb begin
    step_d      = 1'b0;
    phase_d     = '0;
    issued_d    = issued_q;
    done_seen_d = 1'b0;
    clr_cnt_d   = (state_q == StClr) ? clr_cnt_q + 8'd1 : 8'd0;
    cnt_rst_n_d = (state_d != StClr);
    load_d      = (state_d == StLoad);
    limit_d     = (state_d == StLoad) ? act_steps_q : limit_q;
    if (state_d == StRun) begin
      if (state_q != StRun) begin
        step_d   = 1'b1;
        issued_d = 18'd1;
      end else begin
        done_seen_d = done_now;
        if (phase_q == act_period_q) begin
          step_d = !step_q;
          if (!step_q) issued_d = issued_q + 18'd1;
        end else begin
          step_d  = step_q;
          phase_d = phase_q + 8'd1;
        end
      end
    end
  end

  always_comb begin
    rdata_d = '0;
    if (rd_en) begin
      case (off)
        3'd4:    rdata_d = {5'b0, irq_en_q, 1'b0, run_en_q};
        3'd5:    rdata_d = {2'b0, irq_q, timeout_q, overflow_q, empty, full, state_q != StIdle};
        3'd6:    rdata_d = 8'(count_q);
        3'd7:    rdata_d = done_cnt_q;
        default: rdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_steps_q  <= '0;
      act_period_q <= '0;
      dir_q        <= 1'b0;
      phase_q      <= '0;
      issued_q     <= '0;
      step_q       <= 1'b0;
      done_seen_q  <= 1'b0;
      clr_cnt_q    <= '0;
      cnt_rst_n_q  <= 1'b1;
      load_q       <= 1'b0;
      limit_q      <= '0;
      overflow_q   <= 1'b0;
      timeout_q    <= 1'b0;
      irq_q        <= 1'b0;
      done_cnt_q   <= '0;
      rdata_q      <= '0;
    end else begin
      if (state_q == StPop) begin
        act_steps_q  <= head[24:9];
        act_period_q <= head[8:1];
        dir_q        <= head[0];
      end
      phase_q     <= phase_d;
      issued_q    <= issued_d;
      step_q      <= step_d;
      done_seen_q <= done_seen_d;
      clr_cnt_q   <= clr_cnt_d;
      cnt_rst_n_q <= cnt_rst_n_d;
      load_q      <= load_d;
      limit_q     <= limit_d;
      rdata_q     <= rdata_d;
      if (state_q == StNext) done_cnt_q <= done_cnt_q + 8'd1;
      if (flag_clr) begin
        overflow_q <= 1'b0;
        timeout_q  <= 1'b0;
        irq_q      <= 1'b0;
      end else begin
        if (push && full && !pop) overflow_q <= 1'b1;
        if (state_q == StRun && state_d == StErr) begin
          timeout_q <= 1'b1;
          if (irq_en_q) irq_q <= 1'b1;
        end
        if (state_q == StNext && state_d == StIdle && !abort && irq_en_q) irq_q <= 1'b1;
      end
    end
  end

  assign data_out   = rdata_q;
  assign cnt_rst_n  = cnt_rst_n_q;
  assign limit_out  = limit_q;
  assign load_limit = load_q;
  assign step_out   = step_q;
  assign dir_out    = dir_q;
  assign irq        = irq_q;

endmodule

// File: tb/tb_step_move_sequencer.sv
// Directed bench for step_move_sequencer: register vector table plus multi-cycle move scenarios,
// with a behavioural step-counter model that raises done after the programmed number of steps.
module tb_step_move_sequencer;

  localparam logic [15:0] Base = 16'h0010;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] addr = '0;
  logic        cs = 1'b0, wr = 1'b0, rd = 1'b0;
  logic [7:0]  data_in = '0;
  logic [7:0]  data_out;
  logic        cnt_rst_n;
  logic [15:0] limit_out;
  logic        load_limit;
  logic        cnt_done = 1'b0;
  logic        step_out, dir_out, irq;

  step_move_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .addr       (addr),
    .cs         (cs),
    .wr         (wr),
    .rd         (rd),
    .data_in    (data_in),
    .data_out   (data_out),
    .cnt_rst_n  (cnt_rst_n),
    .limit_out  (limit_out),
    .load_limit (load_limit),
    .cnt_done   (cnt_done),
    .step_out   (step_out),
    .dir_out    (dir_out),
    .irq        (irq)
  );

  initial forever #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  logic stall = 1'b0;

  // Counter model and pin monitor, sampled on the falling edge.
  int cyc = 0, rises = 0, clr_lo = 0, loads = 0, gaps = 0, bad_gaps = 0;
  int enc_cnt = 0, last_rise = 0, rise_period = 0, last_fall = 0;
  logic [15:0] enc_lim = '0, last_limit = '0;
  logic step_prev = 1'b0, crst_prev = 1'b1, fall_valid = 1'b0;

  always @(negedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      enc_cnt = 0;
      cnt_done = 1'b0;
      enc_lim = '0;
      fall_valid = 1'b0;
    end else begin
      if (!cnt_rst_n) begin
        enc_cnt = 0;
        cnt_done = 1'b0;
        clr_lo = clr_lo + 1;
        if (crst_prev && fall_valid) begin
          gaps = gaps + 1;
          if (cyc - last_fall != 2) bad_gaps = bad_gaps + 1;
          fall_valid = 1'b0;
        end
      end
      if (load_limit) begin
        loads = loads + 1;
        enc_lim = limit_out;
        last_limit = limit_out;
      end
      if (step_out && !step_prev) begin
        rises = rises + 1;
        enc_cnt = enc_cnt + 1;
        rise_period = cyc - last_rise;
        last_rise = cyc;
      end
      if (!step_out && step_prev) begin
        last_fall = cyc;
        fall_valid = 1'b1;
      end
      if (cnt_rst_n && !stall && enc_lim != 0 && enc_cnt >= int'(enc_lim)) cnt_done = 1'b1;
    end
    step_prev = step_out;
    crst_prev = cnt_rst_n;
  end

  task automatic check(input string nm, input int act, input int exp);
    n_vec = n_vec + 1;
    if (act != exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic bus_write(input logic [2:0] off, input logic [7:0] d);
    @(negedge clk);
    addr = Base + 16'(off);
    data_in = d;
    cs = 1'b1;
    wr = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    wr = 1'b0;
  endtask

  task automatic bus_read(input logic [2:0] off, output logic [7:0] d);
    @(negedge clk);
    addr = Base + 16'(off);
    cs = 1'b1;
    rd = 1'b1;
    @(negedge clk);
    cs = 1'b0;
    rd = 1'b0;
    d = data_out;
  endtask

  task automatic push_seg(input logic [15:0] st, input logic [7:0] per, input logic dir);
    bus_write(3'd0, st[7:0]);
    bus_write(3'd1, st[15:8]);
    bus_write(3'd2, per);
    bus_write(3'd3, {7'b0, dir});
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    cs = 1'b0;
    wr = 1'b0;
    rd = 1'b0;
    stall = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle();
    logic [7:0] s;
    s = 8'h01;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 400; i++) begin
      bus_read(3'd5, s);
      if (!s[0]) break;
    end
    check("idle_reached", int'(s[0]), 0);
  endtask

  task automatic wait_step_high();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (step_out) break;
    end
    check("step_seen", int'(step_out), 1);
  endtask

  typedef struct {
    bit         is_wr;
    logic [2:0] off;
    logic [7:0] data;
    logic [7:0] exp;
  } vec_t;

  vec_t vt[18];
  logic [7:0] rv;
  int r0, c0, l0, g0, b0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{1'b0, 3'd5, 8'h00, 8'h04};
    vt[1]  = '{1'b0, 3'd6, 8'h00, 8'h00};
    vt[2]  = '{1'b0, 3'd7, 8'h00, 8'h00};
    vt[3]  = '{1'b0, 3'd4, 8'h00, 8'h00};
    vt[4]  = '{1'b0, 3'd0, 8'h00, 8'h00};
    vt[5]  = '{1'b1, 3'd4, 8'h04, 8'h00};
    vt[6]  = '{1'b0, 3'd4, 8'h00, 8'h04};
    vt[7]  = '{1'b1, 3'd4, 8'h05, 8'h00};
    vt[8]  = '{1'b0, 3'd4, 8'h00, 8'h05};
    vt[9]  = '{1'b0, 3'd5, 8'h00, 8'h04};
    vt[10] = '{1'b1, 3'd4, 8'h00, 8'h00};
    vt[11] = '{1'b1, 3'd0, 8'h34, 8'h00};
    vt[12] = '{1'b1, 3'd1, 8'h12, 8'h00};
    vt[13] = '{1'b1, 3'd2, 8'h05, 8'h00};
    vt[14] = '{1'b1, 3'd3, 8'h01, 8'h00};
    vt[15] = '{1'b0, 3'd6, 8'h00, 8'h01};
    vt[16] = '{1'b0, 3'd5, 8'h00, 8'h00};
    vt[17] = '{1'b0, 3'd1, 8'h00, 8'h00};

    do_reset();
    check("reset_step", int'(step_out), 0);
    check("reset_cnt_rst_n", int'(cnt_rst_n), 1);
    check("reset_irq", int'(irq), 0);
    for (int i = 0; i < 18; i++) begin
      if (vt[i].is_wr) bus_write(vt[i].off, vt[i].data);
      else begin
        bus_read(vt[i].off, rv);
        check($sformatf("vec%0d", i), int'(rv), int'(vt[i].exp));
      end
    end

    // Single 5-step segment, half-period 4 clocks
    do_reset();
    r0 = rises; c0 = clr_lo; l0 = loads;
    push_seg(16'd5, 8'd3, 1'b1);
    bus_write(3'd4, 8'h01);
    wait_idle();
    check("t1_clr_cycles", clr_lo - c0, 2);
    check("t1_loads", loads - l0, 1);
    check("t1_limit", int'(last_limit), 5);
    check("t1_pulses", rises - r0, 5);
    check("t1_period", rise_period, 8);
    check("t1_dir", int'(dir_out), 1);
    bus_read(3'd7, rv); check("t1_done_cnt", int'(rv), 1);
    bus_read(3'd5, rv); check("t1_status", int'(rv), 8'h04);

    // Fill queue, overflow, then back-to-back execution
    do_reset();
    r0 = rises; g0 = gaps; b0 = bad_gaps;
    for (int i = 0; i < 4; i++) push_seg(16'd2, 8'd1, 1'(i));
    bus_write(3'd3, 8'h00);
    bus_read(3'd5, rv); check("t2_status_full", int'(rv), 8'h0A);
    bus_read(3'd6, rv); check("t2_level", int'(rv), 4);
    bus_write(3'd4, 8'h05);
    wait_idle();
    check("t2_pulses", rises - r0, 8);
    check("t2_transitions", gaps - g0, 3);
    check("t2_idle_gaps", bad_gaps - b0, 0);
    bus_read(3'd7, rv); check("t2_done_cnt", int'(rv), 4);
    bus_read(3'd5, rv); check("t2_status_end", int'(rv), 8'h2C);
    check("t2_irq_pin", int'(irq), 1);

    // Zero-step segment followed by a 2-step segment
    do_reset();
    r0 = rises; c0 = clr_lo; l0 = loads;
    push_seg(16'd0, 8'd1, 1'b0);
    push_seg(16'd2, 8'd1, 1'b1);
    bus_write(3'd4, 8'h01);
    wait_idle();
    check("t3_pulses", rises - r0, 2);
    check("t3_loads", loads - l0, 1);
    check("t3_clr_cycles", clr_lo - c0, 2);
    check("t3_dir", int'(dir_out), 1);
    bus_read(3'd7, rv); check("t3_done_cnt", int'(rv), 2);

    // Stalled encoder -> timeout after steps + SLACK + 1 rising edges
    do_reset();
    stall = 1'b1;
    r0 = rises;
    push_seg(16'd10, 8'd0, 1'b0);
    bus_write(3'd4, 8'h05);
    rv = 8'h00;
    for (int i = 0; i < 200; i++) begin
      bus_read(3'd5, rv);
      if (rv[4]) break;
    end
    check("t4_status_err", int'(rv), 8'h35);
    check("t4_pulses", rises - r0, 27);
    check("t4_step_low", int'(step_out), 0);
    bus_write(3'd4, 8'h08);
    bus_read(3'd5, rv); check("t4_status_clr", int'(rv), 8'h04);
    stall = 1'b0;

    // Abort mid-run with two segments still queued
    do_reset();
    for (int i = 0; i < 3; i++) push_seg(16'd20, 8'd3, 1'b0);
    bus_write(3'd4, 8'h01);
    wait_step_high();
    bus_read(3'd6, rv); check("t5_level_run", int'(rv), 2);
    bus_write(3'd4, 8'h02);
    check("t5_step_abort", int'(step_out), 0);
    check("t5_cnt_rst_n", int'(cnt_rst_n), 1);
    bus_read(3'd5, rv); check("t5_status", int'(rv), 8'h04);
    bus_read(3'd6, rv); check("t5_level", int'(rv), 0);

    // Asynchronous reset in the middle of a step pulse
    do_reset();
    push_seg(16'd0, 8'd0, 1'b0);
    bus_write(3'd4, 8'h05);
    repeat (6) @(negedge clk);
    push_seg(16'd20, 8'd7, 1'b0);
    wait_step_high();
    @(negedge clk);
    addr = Base + 16'd7;
    cs = 1'b1;
    rd = 1'b1;
    @(posedge clk);
    #2;
    cs = 1'b0;
    rd = 1'b0;
    check("t6_pre_step", int'(step_out), 1);
    check("t6_pre_irq", int'(irq), 1);
    check("t6_pre_data", int'(data_out), 1);
    rst_n = 1'b0;
    #1;
    check("t6_rst_step", int'(step_out), 0);
    check("t6_rst_irq", int'(irq), 0);
    check("t6_rst_data", int'(data_out), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bus_read(3'd6, rv); check("t6_level", int'(rv), 0);
    bus_read(3'd7, rv); check("t6_done_cnt", int'(rv), 0);
    bus_read(3'd5, rv); check("t6_status", int'(rv), 8'h04);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/step_move_sequencer.md
Name: step_move_sequencer

Overview:
Bus-programmable controller that sequences the quadrature step counter through a queue of move segments. Each segment is a step target, a pulse half-period and a direction. For each segment the block clears the counter, loads the counter limit, emits step/dir pulses to the motor driver, and stops on the counter's done flag. It sits between the CPU bus, the step counter (limit/done side) and the motor driver.

Parameters:
BASE, 16'h0010, bus base address; the block decodes BASE..BASE+7
FIFO_DEPTH, 4, segment queue depth (power of 2, at least 2)
SLACK, 16, extra steps issued beyond the target before timeout is declared
CLR_CYCLES, 2, length in clocks of the counter clear pulse

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
addr  in  16  bus address
cs  in  1  chip select
wr  in  1  write strobe, qualified by cs
rd  in  1  read strobe, qualified by cs
data_in  in  8  write data
data_out  out  8  registered read data
cnt_rst_n  out  1  counter clear, active-low, registered (glitch-free)
limit_out  out  16  counter limit value
load_limit  out  1  one-cycle counter limit load strobe
cnt_done  in  1  counter done flag (sticky until counter cleared)
step_out  out  1  motor step pulse
dir_out  out  1  motor direction
irq  out  1  interrupt, level

Behaviour:
- Register map (offsets from BASE):
  - 0: SEG_LO W, steps[7:0]
  - 1: SEG_HI W, steps[15:8]
  - 2: PERIOD W, half-period minus 1, in clocks
  - 3: PUSH W, bit0 = dir; the write pushes {steps, period, dir} into the FIFO
  - 4: CTRL W, bit0 = run_en (level), bit1 = abort (self-clearing), bit2 = irq_en, bit3 = irq/flag clear (self-clearing); R returns {5'b0, irq_en, 1'b0, run_en}
  - 5: STATUS R, {2'b0, irq, timeout, overflow, empty, full, busy}
  - 6: LEVEL R, FIFO occupancy
  - 7: DONE_CNT R, segments completed (8-bit, wraps 255->0)
- Reads: registered with 1-cycle latency. data_out is 8'h00 when not selected and for offsets with no readable value. Writes take effect on the clock edge where cs && wr is sampled.
- Reset values:
  - Outputs: data_out=0, cnt_rst_n=1, limit_out=0, load_limit=0, step_out=0, dir_out=0, irq=0.
  - Internal: FIFO empty, all flags 0, DONE_CNT=0, FSM in IDLE.
- FSM:
  - IDLE: if run_en and FIFO not empty -> POP.
  - POP: latch FIFO head into active registers; dir_out is updated here. If steps==0 -> NEXT (no stepping; the counter never asserts done for limit 0). Otherwise -> CLR.
  - CLR: cnt_rst_n=0 for CLR_CYCLES clocks -> LOAD.
  - LOAD: limit_out=steps, load_limit=1 for exactly one cycle -> RUN.
  - RUN: step_out toggles every (period+1) clocks, starting high. Each rising edge increments the issued-step count. When cnt_done is sampled high, finish the current high phase, drive step_out low -> NEXT. If issued > steps+SLACK without cnt_done -> ERR.
  - NEXT: DONE_CNT++ -> POP if run_en and FIFO not empty, else IDLE. On entering IDLE from NEXT, set irq if irq_en.
  - ERR: step_out=0, set timeout, set irq if irq_en. Holds until abort or clear, then -> IDLE.
- Abort: from any state, go to IDLE the next cycle. step_out=0, FIFO flushed, cnt_rst_n=1, DONE_CNT kept.
- run_en cleared mid-segment: the current segment completes, then the FSM goes to IDLE.
- busy = 1 in every state other than IDLE.
- FIFO:
  - Push when full (and no pop in the same cycle): data dropped, overflow sticky set.
  - Push and pop in the same cycle: both take effect; this is legal even when full.
  - Pop never occurs when empty.
- Flags: overflow, timeout and irq are cleared only by the CTRL clear bit or reset. irq = OR of the pending-irq sources.
- Reset mid-operation: every output takes its reset value immediately (asynchronous), so step_out drops mid-pulse.

Test Plan:
1. Push one segment {steps=5, period=3, dir=1}, then set run_en:
   - cnt_rst_n low for 2 clocks, then load_limit pulses with limit_out=5.
   - step_out period is 8 clocks.
   - Encoder model returns done after 5 steps -> exactly 5 pulses, DONE_CNT=1, busy=0.
2. Push 4 segments, then a 5th push while full:
   - overflow=1, LEVEL=4.
   - run_en -> 4 segments execute back-to-back with no IDLE gap, DONE_CNT=4, irq=1 when irq_en=1.
3. Segment with steps=0, followed by steps=2:
   - The first completes with no step_out, cnt_rst_n or load_limit activity.
   - The second issues 2 pulses; DONE_CNT=2.
4. Encoder stalled (cnt_done never asserts), steps=10, SLACK=16:
   - FSM enters ERR after the 27th step rising edge; timeout=1, step_out=0.
   - CTRL clear -> flags 0, FSM in IDLE.
5. Abort during RUN with 2 segments queued:
   - Next cycle: step_out=0, busy=0, LEVEL=0.
   - Read-back of STATUS = 8'h04 (empty only).
6. Assert rst_n=0 mid-pulse:
   - step_out, irq and data_out go to 0 asynchronously.
   - After release: LEVEL=0, DONE_CNT=0, FSM in IDLE.
